// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic valid/ready pipeline register with optional 2-entry skid buffer
//
// Purpose: inter-stage register for the RV32 pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Carries an opaque control field and a data payload. Supports backpressure, flush and,
//   when SKID_EN=1, a skid entry so that o_ready can come straight from a register.
// Ports:
//   i_clk, i_rst           clock (rising edge), asynchronous active-high reset
//   i_flush                synchronous squash of every held entry
//   i_valid/o_ready        upstream handshake, with i_ctrl/i_data
//   o_valid/i_ready        downstream handshake, with o_ctrl/o_data
//   o_occupancy            number of held entries (0..2)
module pipe_stage_elastic #(
    parameter int DATA_W  = 96,
    parameter int CTRL_W  = 16,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_occupancy
);

    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic              accept;
    logic              issue;

    assign o_valid     = (state != EMPTY);
    // With the skid entry, o_ready depends only on the state register and never on i_ready.
    assign o_ready     = SKID_EN ? (state != FULL) : (!o_valid || i_ready);
    assign accept      = i_valid && o_ready;
    assign issue       = o_valid && i_ready;
    assign o_occupancy = state;
    // Bubbles present a zero control word so downstream write-enables stay off.
    assign o_ctrl      = o_valid ? main_ctrl : '0;
    assign o_data      = main_data;

    always_comb begin
        state_n        = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (i_flush) begin
            // Flush wins over everything; a same-cycle accept is simply dropped.
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_n      = BUSY;
                        load_main_in = 1'b1;
                    end
                end
                BUSY: begin
                    if (accept && issue) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        // Only reachable with the skid entry: without it, accepting while
                        // holding an entry implies i_ready, i.e. a simultaneous issue.
                        if (SKID_EN) begin
                            state_n   = FULL;
                            load_skid = 1'b1;
                        end
                    end else if (issue) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (issue) begin
                        state_n        = BUSY;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            state <= state_n;
            if (load_main_in) begin
                main_ctrl <= i_ctrl;
                main_data <= i_data;
            end else if (load_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_ctrl <= i_ctrl;
                skid_data <= i_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - self-checking bench for pipe_stage_elastic (both SKID_EN settings)
module tb_pipe_stage_elastic;

    typedef struct packed {
        logic [15:0] c;
        logic [95:0] d;
    } item_t;

    logic        i_clk;
    logic        i_rst;
    logic        in_flush [2];
    logic        in_valid [2];
    logic        in_ready [2];
    logic [15:0] in_ctrl  [2];
    logic [95:0] in_data  [2];
    logic        out_valid[2];
    logic        out_ready[2];
    logic [15:0] out_ctrl [2];
    logic [95:0] out_data [2];
    logic [1:0]  out_occ  [2];

    int    n_cmp = 0;
    int    n_err = 0;
    bit    check_en = 1'b0;
    item_t mq[2][$];

    // index 0: single entry, index 1: skid buffer
    pipe_stage_elastic #(.DATA_W(96), .CTRL_W(16), .SKID_EN(1'b0)) u_noskid (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(in_flush[0]),
        .i_valid(in_valid[0]), .o_ready(out_ready[0]), .i_ctrl(in_ctrl[0]), .i_data(in_data[0]),
        .o_valid(out_valid[0]), .i_ready(in_ready[0]), .o_ctrl(out_ctrl[0]), .o_data(out_data[0]),
        .o_occupancy(out_occ[0])
    );

    pipe_stage_elastic #(.DATA_W(96), .CTRL_W(16), .SKID_EN(1'b1)) u_skid (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(in_flush[1]),
        .i_valid(in_valid[1]), .o_ready(out_ready[1]), .i_ctrl(in_ctrl[1]), .i_data(in_data[1]),
        .o_valid(out_valid[1]), .i_ready(in_ready[1]), .o_ctrl(out_ctrl[1]), .o_data(out_data[1]),
        .o_occupancy(out_occ[1])
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready(input int k);
        if (k == 1) return mq[1].size() < 2;
        return (mq[0].size() == 0) || in_ready[0];
    endfunction

    // Queue-level reference: accept appends, issue pops the head, flush/reset empty it.
    task automatic model_step();
        bit acc;
        bit iss;
        for (int k = 0; k < 2; k++) begin
            if (i_rst || in_flush[k]) begin
                mq[k].delete();
            end else begin
                acc = in_valid[k] && model_ready(k);
                iss = (mq[k].size() > 0) && in_ready[k];
                if (iss) void'(mq[k].pop_front());
                if (acc) mq[k].push_back('{c: in_ctrl[k], d: in_data[k]});
            end
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int k);
        in_valid[k] = 1'b0;
        in_ready[k] = 1'b1;
        in_flush[k] = 1'b0;
        in_ctrl[k]  = '0;
        in_data[k]  = '0;
    endtask

    task automatic send(input int k, input logic [95:0] d, input logic rdy);
        in_valid[k] = 1'b1;
        in_ready[k] = rdy;
        in_ctrl[k]  = d[15:0] ^ 16'h5a5a;
        in_data[k]  = d;
    endtask

    // Compare process: every negedge outside reset, both DUTs against the model.
    always @(negedge i_clk) begin
        if (check_en && !i_rst) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m%0d_valid", k), 128'(out_valid[k]), 128'(mq[k].size() > 0));
                chk($sformatf("m%0d_ready", k), 128'(out_ready[k]), 128'(model_ready(k)));
                chk($sformatf("m%0d_occ", k), 128'(out_occ[k]), 128'(mq[k].size()));
                if (mq[k].size() > 0) begin
                    chk($sformatf("m%0d_ctrl", k), 128'(out_ctrl[k]), 128'(mq[k][0].c));
                    chk($sformatf("m%0d_data", k), 128'(out_data[k]), 128'(mq[k][0].d));
                end else begin
                    chk($sformatf("m%0d_ctrl0", k), 128'(out_ctrl[k]), 128'(0));
                end
            end
        end
    end

    initial begin
        i_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_flush[k] = 1'b0;
            in_valid[k] = 1'b1;
            in_ready[k] = 1'b1;
            in_ctrl[k]  = 16'hFFFF;
            in_data[k]  = {96{1'b1}};
        end

        // Reset with busy inputs
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_valid", k), 128'(out_valid[k]), 128'(0));
            chk($sformatf("rst%0d_ctrl", k), 128'(out_ctrl[k]), 128'(0));
            chk($sformatf("rst%0d_data", k), 128'(out_data[k]), 128'(0));
            chk($sformatf("rst%0d_occ", k), 128'(out_occ[k]), 128'(0));
        end
        i_rst = 1'b0;
        idle(0);
        idle(1);
        #1;
        chk("rst1_ready", 128'(out_ready[1]), 128'(1));
        chk("rst0_ready", 128'(out_ready[0]), 128'(1));
        check_en = 1'b1;

        // Streaming 1..8 through the skid stage
        for (int i = 1; i <= 8; i++) begin
            send(1, 96'(i), 1'b1);
            tick();
            chk("stream_data", 128'(out_data[1]), 128'(i));
            chk("stream_occ", 128'(out_occ[1]), 128'(1));
        end
        idle(1);
        tick();
        chk("stream_drain", 128'(out_valid[1]), 128'(0));

        // Backpressure: A, B stalled, then drain A, B and send C
        send(1, 96'hA, 1'b0);
        tick();
        chk("bp_occ1", 128'(out_occ[1]), 128'(1));
        send(1, 96'hB, 1'b0);
        tick();
        chk("bp_occ2", 128'(out_occ[1]), 128'(2));
        chk("bp_ready0", 128'(out_ready[1]), 128'(0));
        chk("bp_holdA", 128'(out_data[1]), 128'hA);
        in_valid[1] = 1'b0;
        in_ready[1] = 1'b1;
        tick();
        chk("bp_B", 128'(out_data[1]), 128'hB);
        chk("bp_ready1", 128'(out_ready[1]), 128'(1));
        send(1, 96'hC, 1'b1);
        tick();
        chk("bp_C", 128'(out_data[1]), 128'hC);
        chk("bp_C_occ", 128'(out_occ[1]), 128'(1));
        idle(1);
        tick();

        // Flush while full, D must never appear
        send(1, 96'h11, 1'b0);
        tick();
        send(1, 96'h22, 1'b0);
        tick();
        chk("fl_occ2", 128'(out_occ[1]), 128'(2));
        send(1, 96'hD, 1'b0);
        in_flush[1] = 1'b1;
        tick();
        chk("fl_valid", 128'(out_valid[1]), 128'(0));
        chk("fl_ctrl", 128'(out_ctrl[1]), 128'(0));
        chk("fl_occ", 128'(out_occ[1]), 128'(0));
        idle(1);
        tick();
        chk("fl_noD", 128'(out_valid[1]), 128'(0));

        // Single-entry stall: combinational ready
        send(0, 96'h77, 1'b0);
        tick();
        in_valid[0] = 1'b0;
        #1;
        chk("ns_valid", 128'(out_valid[0]), 128'(1));
        chk("ns_ready0", 128'(out_ready[0]), 128'(0));
        send(0, 96'h88, 1'b1);
        #1;
        chk("ns_ready1", 128'(out_ready[0]), 128'(1));
        tick();
        chk("ns_data", 128'(out_data[0]), 128'h88);
        chk("ns_occ", 128'(out_occ[0]), 128'(1));
        idle(0);
        tick();

        // Asynchronous reset while full
        send(1, 96'h31, 1'b0);
        tick();
        send(1, 96'h32, 1'b0);
        tick();
        chk("ar_occ2", 128'(out_occ[1]), 128'(2));
        #2;
        i_rst = 1'b1;
        mq[0].delete();
        mq[1].delete();
        #1;
        chk("ar_valid", 128'(out_valid[1]), 128'(0));
        chk("ar_ctrl", 128'(out_ctrl[1]), 128'(0));
        chk("ar_data", 128'(out_data[1]), 128'(0));
        chk("ar_occ", 128'(out_occ[1]), 128'(0));
        idle(0);
        idle(1);
        tick();
        i_rst = 1'b0;
        tick();

        // Randomized traffic on both instances against the queue model
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 2; k++) begin
                in_valid[k] = ($urandom_range(0, 3) != 0);
                in_ready[k] = ($urandom_range(0, 2) != 0);
                in_flush[k] = ($urandom_range(0, 19) == 0);
                in_ctrl[k]  = 16'($urandom);
                in_data[k]  = {$urandom, $urandom, $urandom};
            end
            tick();
        end
        idle(0);
        idle(1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
